// File: rtl/ripple_count_capture.sv
// Settles an asynchronous ripple-counter value into clk, flags wraps/clears and
// hands wrap events over a valid/ready port. Optional SKIP_CHECK_EN adds seq_err.
module ripple_count_capture #(
    parameter int CNT_W    = 4,
    parameter int EVT_W    = 8,
    parameter int STABLE_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] cnt_q,
    output logic             cnt_vld,
    output logic             wrap_pulse,
    output logic             clr_pulse,
    output logic [EVT_W-1:0] wrap_cnt,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [EVT_W-1:0] evt_data,
    output logic             ovf,
    input  logic             clr_ovf,
    output logic             seq_err
);

    localparam int                  STAB_W   = $clog2(STABLE_N + 1);
    localparam logic [STAB_W-1:0]   STAB_MAX = STAB_W'(STABLE_N);
    localparam logic [STAB_W-1:0]   STAB_ACC = STAB_W'(STABLE_N - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

    logic [CNT_W-1:0]  s1_q, s2_q;
    logic [1:0]        prime_q;
    logic [CNT_W-1:0]  cand_q, cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [CNT_W-1:0]  val_q, val_d;
    logic              vld_q, vld_d;
    logic              wrap_q, wrap_d;
    logic              clr_q, clr_d;
    logic [EVT_W-1:0]  wcnt_q, wcnt_d;
    logic              evv_q, evv_d;
    logic [EVT_W-1:0]  evd_q, evd_d;
    logic              ovf_q, ovf_d;
    logic              accept, update, is_wrap, ovf_set;

    always_comb begin
        cand_d  = cand_q;
        stab_d  = stab_q;
        val_d   = val_q;
        vld_d   = vld_q;
        wrap_d  = 1'b0;
        clr_d   = 1'b0;
        wcnt_d  = wcnt_q;
        evv_d   = evv_q;
        evd_d   = evd_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
        is_wrap = 1'b0;
        ovf_set = 1'b0;

        // The sync flops hold reset zeros, not samples, for two edges after
        // reset; the filter only starts counting once s2 carries a real sample.
        if (prime_q[1]) begin
            if (s2_q != cand_q) begin
                cand_d = s2_q;
                stab_d = STAB_W'(1);
            end else begin
                if (stab_q < STAB_MAX) begin
                    stab_d = stab_q + STAB_W'(1);
                end
                accept = (stab_q == STAB_ACC);
            end
        end

        update = accept && (!vld_q || (cand_q != val_q));
        if (update) begin
            val_d = cand_q;
            vld_d = 1'b1;
            if (vld_q && (cand_q == '0)) begin
                if (val_q == CNT_MAX) begin
                    is_wrap = 1'b1;
                end else begin
                    clr_d = 1'b1;
                end
            end
        end

        if (is_wrap) begin
            wrap_d = 1'b1;
            wcnt_d = wcnt_q + EVT_W'(1);
            if (!evv_q || evt_ready) begin
                evv_d = 1'b1;
                evd_d = wcnt_q + EVT_W'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end else if (evv_q && evt_ready) begin
            evv_d = 1'b0;
        end

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prime_q <= '0;
            cand_q  <= '0;
            stab_q  <= '0;
            val_q   <= '0;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
            clr_q   <= 1'b0;
            wcnt_q  <= '0;
            evv_q   <= 1'b0;
            evd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= cnt_in;
            s2_q    <= s1_q;
            prime_q <= {prime_q[0], 1'b1};
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            val_q   <= val_d;
            vld_q   <= vld_d;
            wrap_q  <= wrap_d;
            clr_q   <= clr_d;
            wcnt_q  <= wcnt_d;
            evv_q   <= evv_d;
            evd_q   <= evd_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SKIP_CHECK_EN
    logic seq_q, seq_d;

    always_comb begin
        seq_d = seq_q;
        if (update && vld_q && (cand_q != '0) && (cand_q != val_q + CNT_W'(1))) begin
            seq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= 1'b0;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign seq_err = seq_q;
`else
    assign seq_err = 1'b0;
`endif

    assign cnt_q      = val_q;
    assign cnt_vld    = vld_q;
    assign wrap_pulse = wrap_q;
    assign clr_pulse  = clr_q;
    assign wrap_cnt   = wcnt_q;
    assign evt_valid  = evv_q;
    assign evt_data   = evd_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Randomised plus directed bench for ripple_count_capture against a
// sample-history reference model.
module tb_ripple_count_capture;

    localparam int CNT_W    = 4;
    localparam int EVT_W    = 8;
    localparam int STABLE_N = 2;
    localparam int CMOD     = 1 << CNT_W;
    localparam int EMOD     = 1 << EVT_W;
    localparam int HOLD     = STABLE_N + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cnt_in;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_vld;
    logic             wrap_pulse;
    logic             clr_pulse;
    logic [EVT_W-1:0] wrap_cnt;
    logic             evt_valid;
    logic             evt_ready;
    logic [EVT_W-1:0] evt_data;
    logic             ovf;
    logic             clr_ovf;
    logic             seq_err;

    ripple_count_capture #(.CNT_W(CNT_W), .EVT_W(EVT_W), .STABLE_N(STABLE_N)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_q(cnt_q), .cnt_vld(cnt_vld),
        .wrap_pulse(wrap_pulse), .clr_pulse(clr_pulse), .wrap_cnt(wrap_cnt),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .ovf(ovf), .clr_ovf(clr_ovf), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit rand_hs  = 1'b0;

    // reference model: raw samples since reset, plus the visible outputs
    int hist[$];
    int m_cnt, m_vld, m_wrap, m_clr, m_wcnt, m_evv, m_evd, m_ovf, m_seq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int n, last, v;
        bit acc, wrap, clr, oset;
        wrap = 1'b0; clr = 1'b0; oset = 1'b0; acc = 1'b0;
        if (rst) begin
            hist.delete();
            m_cnt = 0; m_vld = 0; m_wrap = 0; m_clr = 0; m_wcnt = 0;
            m_evv = 0; m_evd = 0; m_ovf = 0; m_seq = 0;
            return;
        end
        hist.push_back(int'(cnt_in));
        n = hist.size();
        // the filter sees a sample two edges after it is taken; a code is
        // accepted when its run of samples reaches exactly STABLE_N
        if (n >= STABLE_N + 2) begin
            last = n - 3;
            v    = hist[last];
            acc  = 1'b1;
            for (int i = 0; i < STABLE_N; i++) if (hist[last - i] != v) acc = 1'b0;
            if (last - STABLE_N >= 0 && hist[last - STABLE_N] == v) acc = 1'b0;
            if (acc && (m_vld == 0 || v != m_cnt)) begin
                if (m_vld != 0) begin
                    if (v == 0 && m_cnt == CMOD - 1) wrap = 1'b1;
                    else if (v == 0) clr = 1'b1;
`ifdef SKIP_CHECK_EN
                    else if (v != (m_cnt + 1) % CMOD) m_seq = 1;
`endif
                end
                m_cnt = v;
                m_vld = 1;
            end
        end
        if (wrap) begin
            m_wcnt = (m_wcnt + 1) % EMOD;
            if (m_evv == 0 || evt_ready) begin
                m_evv = 1;
                m_evd = m_wcnt;
            end else begin
                oset = 1'b1;
            end
        end else if (m_evv != 0 && evt_ready) begin
            m_evv = 0;
        end
        if (oset) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        m_wrap = int'(wrap);
        m_clr  = int'(clr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("cnt_q",      32'(cnt_q),      m_cnt);
        check("cnt_vld",    32'(cnt_vld),    m_vld);
        check("wrap_pulse", 32'(wrap_pulse), m_wrap);
        check("clr_pulse",  32'(clr_pulse),  m_clr);
        check("wrap_cnt",   32'(wrap_cnt),   m_wcnt);
        check("evt_valid",  32'(evt_valid),  m_evv);
        check("evt_data",   32'(evt_data),   m_evd);
        check("ovf",        32'(ovf),        m_ovf);
        check("seq_err",    32'(seq_err),    m_seq);
    endtask

    task automatic hold(input int v, input int n);
        cnt_in = CNT_W'(v);
        repeat (n) begin
            if (rand_hs) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                clr_ovf   = ($urandom_range(0, 7) == 0);
            end
            tick();
        end
    endtask

    task automatic ramp(input int from, input int to);
        for (int v = from; v <= to; v++) hold(v, HOLD);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int cur, mode;
        rst = 1'b1; cnt_in = CNT_W'(5); evt_ready = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        rst = 1'b0;
        hold(5, 6);

        // ripple glitch between settled codes
        hold(6, 4); hold(7, 4);
        hold(6, 1); hold(4, 1); hold(0, 1); hold(8, 1);
        hold(8, 4);

        // single wrap with consumer ready
        evt_ready = 1'b1;
        for (int v = 9; v < CMOD; v++) hold(v, 4);
        hold(0, 4);

        // backpressure: two wraps, overflow, clear, then drain
        evt_ready = 1'b0;
        ramp(1, CMOD - 1); hold(0, HOLD);
        ramp(1, CMOD - 1); hold(0, HOLD);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        evt_ready = 1'b1; tick(); tick();

        // transfer and new wrap on the same edge
        evt_ready = 1'b0;
        ramp(1, CMOD - 1); hold(0, HOLD);
        ramp(1, CMOD - 1);
        cnt_in = '0;
        repeat (STABLE_N + 1) tick();
        evt_ready = 1'b1; tick();
        evt_ready = 1'b0; hold(0, 3);

        // clear from a non-max value, then a skipped code
        ramp(1, 9); hold(0, 4);
        ramp(1, 2); hold(5, 4);

        // randomised traffic
        rand_hs = 1'b1;
        cur = 5;
        for (int seg = 0; seg < 1200; seg++) begin
            mode = int'($urandom_range(0, 19));
            if (mode < 12) begin
                cur = (cur + 1) % CMOD;
                hold(cur, int'($urandom_range(1, 5)));
            end else if (mode < 15) begin
                hold(int'($urandom_range(0, CMOD - 1)), 1);
            end else if (mode < 17) begin
                cur = int'($urandom_range(0, CMOD - 1));
                hold(cur, int'($urandom_range(1, 5)));
            end else if (mode < 19) begin
                cur = 0;
                hold(cur, int'($urandom_range(1, 5)));
            end else begin
                rst = 1'b1;
                hold(cur, int'($urandom_range(1, 2)));
                rst = 1'b0;
            end
        end

        // enough wraps to roll wrap_cnt past its maximum
        for (int w = 0; w < 270; w++) begin
            hold(CMOD - 1, HOLD);
            hold(0, HOLD);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
